// File: rtl/toggle_counter.sv
// WIDTH toggle cells sharing one clock: per-bit T flip-flops or a modulo up/down counter
// with a registered one-cycle WRAP pulse for the Morse symbol sequencer.
module toggle_counter #(
  parameter int unsigned      WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] MAX     = {WIDTH{1'b1}}
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [1:0]       MODE,
  input  logic [WIDTH-1:0] T,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             WRAP
);

  typedef enum logic [1:0] {
    MODE_HOLD   = 2'b00,
    MODE_TOGGLE = 2'b01,
    MODE_UP     = 2'b10,
    MODE_DOWN   = 2'b11
  } mode_t;

  logic [WIDTH-1:0] q_next;
  logic             wrap_next;

  // UP uses >= so a value loaded above MAX still wraps to zero on the next count.
  always_comb begin
    q_next    = Q;
    wrap_next = 1'b0;
    if (LOAD) begin
      q_next = D;
    end else if (EN) begin
      case (mode_t'(MODE))
        MODE_TOGGLE: q_next = Q ^ T;
        MODE_UP: begin
          if (Q >= MAX) begin
            q_next    = '0;
            wrap_next = 1'b1;
          end else begin
            q_next = Q + WIDTH'(1);
          end
        end
        MODE_DOWN: begin
          if (Q == '0) begin
            q_next    = MAX;
            wrap_next = 1'b1;
          end else begin
            q_next = Q - WIDTH'(1);
          end
        end
        default: q_next = Q;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      Q    <= RST_VAL;
      WRAP <= 1'b0;
    end else begin
      Q    <= q_next;
      WRAP <= wrap_next;
    end
  end

endmodule

// File: tb/tb_toggle_counter.sv
// Self-checking bench for toggle_counter: an 8-bit MAX=9 instance driven from a vector table
// and hand sequences, plus a 1-bit MAX=1 instance behaving as a plain T flip-flop.
module tb_toggle_counter;

  logic       CLK = 1'b0;
  logic       rst, en, load;
  logic [1:0] mode;
  logic [7:0] t, d, q;
  logic       wrap;

  logic       s_rst, s_en, s_load;
  logic [1:0] s_mode;
  logic [0:0] s_t, s_d, s_q;
  logic       s_wrap;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic [7:0] t;
    logic       load;
    logic [7:0] d;
    logic [7:0] exp_q;
    logic       exp_wrap;
  } vec_t;

  typedef struct {
    logic [7:0] q;
    logic       wrap;
    int         id;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  always #5 CLK = ~CLK;

  toggle_counter #(.WIDTH(8), .RST_VAL(8'hFF), .MAX(8'd9)) dut (
    .CLK(CLK), .RST(rst), .EN(en), .MODE(mode), .T(t),
    .LOAD(load), .D(d), .Q(q), .WRAP(wrap)
  );

  toggle_counter #(.WIDTH(1), .RST_VAL(1'b1), .MAX(1'b1)) dut_tff (
    .CLK(CLK), .RST(s_rst), .EN(s_en), .MODE(s_mode), .T(s_t),
    .LOAD(s_load), .D(s_d), .Q(s_q), .WRAP(s_wrap)
  );

  task automatic addVec(input logic r, input logic e, input logic [1:0] m, input logic [7:0] tv,
                        input logic l, input logic [7:0] dv, input logic [7:0] eq, input logic ew);
    vec_t v;
    v.rst = r; v.en = e; v.mode = m; v.t = tv; v.load = l; v.d = dv;
    v.exp_q = eq; v.exp_wrap = ew;
    vecs.push_back(v);
  endtask

  // Drive on the falling edge and queue what the next rising edge must produce.
  task automatic applyStimulus(input vec_t v, input int id);
    exp_t e;
    @(negedge CLK);
    rst = v.rst; en = v.en; mode = v.mode; t = v.t; load = v.load; d = v.d;
    e.q = v.exp_q; e.wrap = v.exp_wrap; e.id = id;
    sb.push_back(e);
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      mismatched++;
      compared++;
      $display("[TB] FAIL scoreboard_empty: got no expectation, required one");
      return;
    end
    e = sb.pop_front();
    compared++;
    if (q !== e.q) begin
      mismatched++;
      $display("[TB] FAIL vec%0d_q: got %h, required %h", e.id, q, e.q);
    end
    compared++;
    if (wrap !== e.wrap) begin
      mismatched++;
      $display("[TB] FAIL vec%0d_wrap: got %b, required %b", e.id, wrap, e.wrap);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic [1:0] m, input logic [7:0] tv,
                      input logic l, input logic [7:0] dv, input logic [7:0] eq, input logic ew,
                      input int id);
    vec_t v;
    v.rst = r; v.en = e; v.mode = m; v.t = tv; v.load = l; v.d = dv;
    v.exp_q = eq; v.exp_wrap = ew;
    applyStimulus(v, id);
    checkOutput();
  endtask

  task automatic checkTff(input logic [0:0] eq, input logic ew, input int id);
    compared++;
    if (s_q !== eq) begin
      mismatched++;
      $display("[TB] FAIL tff%0d_q: got %b, required %b", id, s_q, eq);
    end
    compared++;
    if (s_wrap !== ew) begin
      mismatched++;
      $display("[TB] FAIL tff%0d_wrap: got %b, required %b", id, s_wrap, ew);
    end
  endtask

  initial begin
    logic [0:0] tff_exp;
    logic       tff_wrap;

    rst = 1'b1; en = 1'b0; mode = 2'b00; t = '0; load = 1'b0; d = '0;
    s_rst = 1'b1; s_en = 1'b0; s_mode = 2'b00; s_t = '0; s_load = 1'b0; s_d = '0;

    //     rst en mode   t      load d      q      wrap
    addVec(1, 1, 2'b10, 8'h00, 1, 8'h33, 8'hFF, 0);   // reset beats LOAD/UP
    addVec(0, 0, 2'b00, 8'h00, 0, 8'h00, 8'hFF, 0);
    addVec(0, 1, 2'b00, 8'hFF, 0, 8'h00, 8'hFF, 0);
    addVec(0, 1, 2'b10, 8'h00, 0, 8'h00, 8'h00, 1);   // UP from above MAX wraps
    addVec(0, 1, 2'b10, 8'h00, 0, 8'h00, 8'h01, 0);
    addVec(0, 0, 2'b00, 8'h00, 1, 8'h00, 8'h00, 0);
    addVec(0, 1, 2'b01, 8'hA5, 0, 8'h00, 8'hA5, 0);
    addVec(0, 1, 2'b01, 8'hA5, 0, 8'h00, 8'h00, 0);
    addVec(0, 0, 2'b01, 8'hFF, 0, 8'h00, 8'h00, 0);
    addVec(0, 0, 2'b00, 8'h00, 1, 8'h02, 8'h02, 0);
    addVec(0, 1, 2'b11, 8'h00, 0, 8'h00, 8'h01, 0);
    addVec(0, 1, 2'b11, 8'h00, 0, 8'h00, 8'h00, 0);
    addVec(0, 1, 2'b11, 8'h00, 0, 8'h00, 8'h09, 1);
    addVec(0, 1, 2'b11, 8'h00, 0, 8'h00, 8'h08, 0);
    addVec(0, 0, 2'b00, 8'h00, 1, 8'h0C, 8'h0C, 0);
    addVec(0, 1, 2'b11, 8'h00, 0, 8'h00, 8'h0B, 0);
    addVec(0, 1, 2'b10, 8'h00, 1, 8'h33, 8'h33, 0);
    for (int i = 0; i < 5; i++)
      addVec(0, 0, 2'b10, 8'h00, 0, 8'h00, 8'h33, 0);
    addVec(0, 0, 2'b00, 8'h00, 1, 8'h03, 8'h03, 0);
    addVec(0, 1, 2'b10, 8'h00, 0, 8'h00, 8'h04, 0);
    addVec(0, 1, 2'b10, 8'h00, 0, 8'h00, 8'hFF, 0);   // RST preempts mid-count: fixed below
    vecs[vecs.size()-1].rst = 1'b1;
    addVec(0, 0, 2'b00, 8'h00, 1, 8'h09, 8'h09, 0);
    addVec(0, 1, 2'b10, 8'h00, 0, 8'h00, 8'h00, 1);
    addVec(0, 1, 2'b11, 8'h00, 1, 8'h55, 8'h55, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i], i);
      checkOutput();
    end

    // Full UP cycle through the modulus: WRAP only on the 9->0 edge.
    step(0, 0, 2'b00, 8'h00, 1, 8'h00, 8'h00, 0, 100);
    for (int i = 1; i <= 10; i++)
      step(0, 1, 2'b10, 8'h00, 0, 8'h00, (i == 10) ? 8'h00 : 8'(i), (i == 10), 100 + i);
    step(0, 1, 2'b10, 8'h00, 0, 8'h00, 8'h01, 0, 111);
    step(0, 1, 2'b00, 8'h00, 0, 8'h00, 8'h01, 0, 112);

    // Single-bit instance: T flip-flop with T = EN.
    @(negedge CLK);
    s_rst = 1'b1; s_en = 1'b1; s_mode = 2'b10;
    @(posedge CLK); #1;
    checkTff(1'b1, 1'b0, 0);
    tff_exp = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge CLK);
      s_rst = 1'b0;
      tff_wrap = tff_exp[0];
      tff_exp  = ~tff_exp;
      @(posedge CLK); #1;
      checkTff(tff_exp, tff_wrap, i);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
